// File: rtl/lpc_io_target.sv
// ---------------------------------------------------------------------------
// lpc_io_target
// LPC bus target for host I/O read and I/O write cycles that fall inside a
// 2**WIN_BITS byte register window at BASE_ADDR. Decodes LFRAME#/LAD and
// returns SYNC, read data and turnaround on LAD. Register-file accesses are
// issued as single-clock Wr/Rd strobes.
//
// Ports
//   LpcClock  in   LPC clock, all logic on the rising edge
//   PciReset  in   asynchronous active-low reset
//   LFRAME_n  in   LPC frame (active-low)
//   LAD_in    in   LAD nibble as seen on the pad
//   LAD_out   out  LAD nibble driven while LAD_oe=1
//   LAD_oe    out  1 = target drives LAD
//   Addr      out  register offset (cycle address[7:0])
//   DataWr    out  write data, valid while Wr=1
//   Wr        out  one-clock write strobe
//   Rd        out  one-clock read strobe; DataRd sampled on the edge ending it
//   DataRd    in   read data from the register file for Addr
// ---------------------------------------------------------------------------
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h0700,
    parameter int          WIN_BITS  = 8,
    parameter int          SYNC_WAIT = 0
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFRAME_n,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    output logic [7:0] Addr,
    output logic [7:0] DataWr,
    output logic       Wr,
    output logic       Rd,
    input  logic [7:0] DataRd
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYC,
        ST_ADDR,
        ST_WDAT,
        ST_HTAR,
        ST_SYNC,
        ST_RDAT,
        ST_TTAR
    } state_t;

    localparam logic [15:0] WIN_MASK    = 16'hFFFF << WIN_BITS;
    localparam logic [3:0]  SYNC_WAIT_L = 4'(SYNC_WAIT);

    state_t      state_reg,   state_next;
    logic [1:0]  cnt_reg,     cnt_next;      // nibble index within a multi-clock state
    logic [3:0]  wait_reg,    wait_next;     // long-wait SYNC nibbles already sent
    logic        is_wr_reg,   is_wr_next;
    logic [15:0] addr_sh_reg, addr_sh_next;  // address shift register, MSB nibble first
    logic [7:0]  wdata_reg,   wdata_next;
    logic [7:0]  rdata_reg,   rdata_next;
    logic [7:0]  addr_reg,    addr_next;
    logic [7:0]  datawr_reg,  datawr_next;

    logic [15:0] addr_new;
    logic        sync_ready;

    assign addr_new   = {addr_sh_reg[11:0], LAD_in};
    assign sync_ready = (wait_reg == SYNC_WAIT_L);

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 2'd0;
            wait_reg    <= 4'd0;
            is_wr_reg   <= 1'b0;
            addr_sh_reg <= 16'h0000;
            wdata_reg   <= 8'h00;
            rdata_reg   <= 8'h00;
            addr_reg    <= 8'h00;
            datawr_reg  <= 8'h00;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wait_reg    <= wait_next;
            is_wr_reg   <= is_wr_next;
            addr_sh_reg <= addr_sh_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            addr_reg    <= addr_next;
            datawr_reg  <= datawr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        wait_next    = wait_reg;
        is_wr_next   = is_wr_reg;
        addr_sh_next = addr_sh_reg;
        wdata_next   = wdata_reg;
        rdata_next   = rdata_reg;
        addr_next    = addr_reg;
        datawr_next  = datawr_reg;

        case (state_reg)
            ST_IDLE: state_next = ST_IDLE;

            ST_CYC: begin
                cnt_next = 2'd0;
                if (LAD_in[3:1] == 3'b000) begin
                    is_wr_next = 1'b0;
                    state_next = ST_ADDR;
                end else if (LAD_in[3:1] == 3'b001) begin
                    is_wr_next = 1'b1;
                    state_next = ST_ADDR;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_ADDR: begin
                addr_sh_next = addr_new;
                cnt_next     = cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) begin
                    cnt_next = 2'd0;
                    if ((addr_new & WIN_MASK) == (BASE_ADDR & WIN_MASK))
                        state_next = is_wr_reg ? ST_WDAT : ST_HTAR;
                    else
                        state_next = ST_IDLE;
                end
            end

            ST_WDAT: begin
                if (cnt_reg == 2'd0) begin
                    wdata_next[3:0] = LAD_in;
                    cnt_next        = 2'd1;
                end else begin
                    wdata_next[7:4] = LAD_in;
                    cnt_next        = 2'd0;
                    state_next      = ST_HTAR;
                end
            end

            ST_HTAR: begin
                if (cnt_reg == 2'd0) begin
                    cnt_next = 2'd1;
                end else begin
                    cnt_next   = 2'd0;
                    wait_next  = 4'd0;
                    state_next = ST_SYNC;
                    // Register-file address/data become visible from the first
                    // SYNC clock so they are settled before the strobe.
                    addr_next  = addr_sh_reg[7:0];
                    if (is_wr_reg)
                        datawr_next = wdata_reg;
                end
            end

            ST_SYNC: begin
                if (sync_ready) begin
                    cnt_next = 2'd0;
                    if (is_wr_reg) begin
                        state_next = ST_TTAR;
                    end else begin
                        rdata_next = DataRd;
                        state_next = ST_RDAT;
                    end
                end else begin
                    wait_next = wait_reg + 4'd1;
                end
            end

            ST_RDAT: begin
                if (cnt_reg == 2'd0) begin
                    cnt_next = 2'd1;
                end else begin
                    cnt_next   = 2'd0;
                    state_next = ST_TTAR;
                end
            end

            ST_TTAR: begin
                if (cnt_reg == 2'd0) begin
                    cnt_next = 2'd1;
                end else begin
                    cnt_next   = 2'd0;
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase

        // START overrides everything: the host may abort or restart at any clock.
        if (!LFRAME_n)
            state_next = (LAD_in == 4'h0) ? ST_CYC : ST_IDLE;
    end

    // Bus outputs decode directly from registered state so reset releases
    // LAD immediately.
    always_comb begin
        LAD_oe  = 1'b0;
        LAD_out = 4'hF;
        Wr      = 1'b0;
        Rd      = 1'b0;
        case (state_reg)
            ST_SYNC: begin
                LAD_oe  = 1'b1;
                LAD_out = sync_ready ? 4'h0 : 4'h6;
                Wr      = sync_ready &  is_wr_reg;
                Rd      = sync_ready & ~is_wr_reg;
            end
            ST_RDAT: begin
                LAD_oe  = 1'b1;
                LAD_out = (cnt_reg == 2'd0) ? rdata_reg[3:0] : rdata_reg[7:4];
            end
            ST_TTAR: begin
                LAD_oe  = (cnt_reg == 2'd0);
                LAD_out = 4'hF;
            end
            default: begin
                LAD_oe  = 1'b0;
                LAD_out = 4'hF;
            end
        endcase
    end

    assign Addr   = addr_reg;
    assign DataWr = datawr_reg;

endmodule

// File: tb/tb_lpc_io_target.sv
// ---------------------------------------------------------------------------
// tb_lpc_io_target
// Two targets: u0 with SYNC_WAIT=0, u1 with SYNC_WAIT=3. Each frame task
// pushes the expected bus events (strobes and driven LAD nibbles, tagged with
// the clock they must appear in) into a per-target queue; a negedge monitor
// pops and compares whenever a target presents Wr, Rd or LAD_oe.
// ---------------------------------------------------------------------------
module tb_lpc_io_target;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_LAD = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic       clk;
    logic       rst_n   [2];
    logic       lframe_n[2];
    logic [3:0] lad_in  [2];
    logic [7:0] datard  [2];
    logic [3:0] lad_out [2];
    logic       lad_oe  [2];
    logic [7:0] addr_o  [2];
    logic [7:0] dwr_o   [2];
    logic       wr_o    [2];
    logic       rd_o    [2];

    int  checks = 0;
    int  errors = 0;
    int  cyc_cnt = 0;
    ev_t q0[$];
    ev_t q1[$];

    lpc_io_target #(.SYNC_WAIT(0)) u0 (
        .LpcClock(clk), .PciReset(rst_n[0]), .LFRAME_n(lframe_n[0]),
        .LAD_in(lad_in[0]), .LAD_out(lad_out[0]), .LAD_oe(lad_oe[0]),
        .Addr(addr_o[0]), .DataWr(dwr_o[0]), .Wr(wr_o[0]), .Rd(rd_o[0]),
        .DataRd(datard[0])
    );

    lpc_io_target #(.SYNC_WAIT(3)) u1 (
        .LpcClock(clk), .PciReset(rst_n[1]), .LFRAME_n(lframe_n[1]),
        .LAD_in(lad_in[1]), .LAD_out(lad_out[1]), .LAD_oe(lad_oe[1]),
        .Addr(addr_o[1]), .DataWr(dwr_o[1]), .Wr(wr_o[1]), .Rd(rd_o[1]),
        .DataRd(datard[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic string kname(input int k);
        if (k == K_WR) return "WR";
        if (k == K_RD) return "RD";
        return "LAD";
    endfunction

    function automatic void push(input int u, input int kind, input int cyc,
                                 input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.cyc = cyc; e.a = a; e.d = d;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    // Report expected events whose clock has already passed.
    task automatic flush_missed(input int u);
        ev_t e;
        while (((u == 0) ? q0.size() : q1.size()) > 0) begin
            e = (u == 0) ? q0[0] : q1[0];
            if (e.cyc >= cyc_cnt) break;
            if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            checks++;
            errors++;
            $display("FAIL missing u%0d %s cyc %0d: got nothing, required a=%h d=%h",
                     u, kname(e.kind), e.cyc, e.a, e.d);
        end
    endtask

    task automatic pop_cmp(input int u, input int kind, input logic [7:0] a,
                           input logic [7:0] d);
        ev_t e;
        int  n;
        checks++;
        n = (u == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            errors++;
            $display("FAIL unexpected u%0d %s cyc %0d: got a=%h d=%h, required none",
                     u, kname(kind), cyc_cnt, a, d);
            return;
        end
        e = (u == 0) ? q0[0] : q1[0];
        if (e.cyc > cyc_cnt) begin
            errors++;
            $display("FAIL early u%0d %s cyc %0d: got a=%h d=%h, required at cyc %0d %s a=%h d=%h",
                     u, kname(kind), cyc_cnt, a, d, e.cyc, kname(e.kind), e.a, e.d);
            return;
        end
        if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        if (e.kind != kind || e.a !== a || e.d !== d) begin
            errors++;
            $display("FAIL event u%0d cyc %0d: got %s a=%h d=%h, required %s a=%h d=%h",
                     u, cyc_cnt, kname(kind), a, d, kname(e.kind), e.a, e.d);
        end else begin
            $display("ok u%0d cyc %0d %s a=%h d=%h", u, cyc_cnt, kname(kind), a, d);
        end
    endtask

    task automatic mon(input int u);
        flush_missed(u);
        if (wr_o[u] === 1'b1)   pop_cmp(u, K_WR,  addr_o[u], dwr_o[u]);
        if (rd_o[u] === 1'b1)   pop_cmp(u, K_RD,  addr_o[u], 8'h00);
        if (lad_oe[u] === 1'b1) pop_cmp(u, K_LAD, 8'h00, {4'h0, lad_out[u]});
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("ok %s = %h", name, got);
        end
    endtask

    task automatic chk_reset_vals(input int u);
        chk($sformatf("u%0d reset LAD_oe", u),  {7'd0, lad_oe[u]}, 8'h00);
        chk($sformatf("u%0d reset LAD_out", u), {4'd0, lad_out[u]}, 8'h0F);
        chk($sformatf("u%0d reset Addr", u),    addr_o[u], 8'h00);
        chk($sformatf("u%0d reset DataWr", u),  dwr_o[u], 8'h00);
        chk($sformatf("u%0d reset Wr", u),      {7'd0, wr_o[u]}, 8'h00);
        chk($sformatf("u%0d reset Rd", u),      {7'd0, rd_o[u]}, 8'h00);
    endtask

    // One host frame. abort_at / rst_at are frame clock indices (-1 = none).
    task automatic frame(input int u, input logic [3:0] cyc_nib, input logic [15:0] a,
                         input logic [7:0] d, input bit hit,
                         input int abort_at, input int rst_at);
        bit          wr;
        int          nw, s, ready, last, t0;
        logic [15:0] sh;
        wr    = (cyc_nib[3:1] == 3'b001);
        nw    = (u == 0) ? 0 : 3;
        s     = wr ? 10 : 8;
        ready = s + nw;
        last  = ready + (wr ? 2 : 4);
        if (!wr) datard[u] = d;
        t0 = 0;
        for (int n = 0; n <= last; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                t0 = cyc_cnt;
                if (hit) begin
                    for (int p = s; p <= last; p++) begin
                        if ((abort_at < 0 || p <= abort_at) && (rst_at < 0 || p < rst_at)) begin
                            if (p < ready)      push(u, K_LAD, t0 + p, 8'h00, 8'h06);
                            else if (p == ready) begin
                                push(u, wr ? K_WR : K_RD, t0 + p, a[7:0], wr ? d : 8'h00);
                                push(u, K_LAD, t0 + p, 8'h00, 8'h00);
                            end
                            else if (!wr && p == ready + 1) push(u, K_LAD, t0 + p, 8'h00, {4'h0, d[3:0]});
                            else if (!wr && p == ready + 2) push(u, K_LAD, t0 + p, 8'h00, {4'h0, d[7:4]});
                            else if (p == last - 1)         push(u, K_LAD, t0 + p, 8'h00, 8'h0F);
                        end
                    end
                end
            end
            lframe_n[u] = 1'b1;
            lad_in[u]   = 4'hF;
            if (n == 0) begin
                lframe_n[u] = 1'b0;
                lad_in[u]   = 4'h0;
            end else if (n == 1) begin
                lad_in[u] = cyc_nib;
            end else if (n >= 2 && n <= 5) begin
                sh = a >> (4 * (5 - n));
                lad_in[u] = sh[3:0];
            end else if (wr && n == 6) begin
                lad_in[u] = d[3:0];
            end else if (wr && n == 7) begin
                lad_in[u] = d[7:4];
            end
            if (n == abort_at) begin
                lframe_n[u] = 1'b0;
                lad_in[u]   = 4'hF;
            end
            if (rst_at >= 0 && n == rst_at + 1) rst_n[u] = 1'b1;
            if (n == rst_at) begin
                #1 rst_n[u] = 1'b0;
                #1 chk_reset_vals(u);
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            lframe_n[0] = 1'b1; lad_in[0] = 4'hF;
            lframe_n[1] = 1'b1; lad_in[1] = 4'hF;
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; lframe_n[u] = 1'b1; lad_in[u] = 4'hF; datard[u] = 8'h00;
        end
        idle(3);
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle(2);

        // SYNC_WAIT=0 target
        frame(0, 4'h2, 16'h0704, 8'h5A, 1'b1, -1, -1);   // write, in window
        frame(0, 4'h0, 16'h07A5, 8'hC3, 1'b1, -1, -1);   // read, back-to-back
        idle(2);
        frame(0, 4'h2, 16'h0804, 8'h11, 1'b0, -1, -1);   // outside window
        frame(0, 4'h4, 16'h0704, 8'h22, 1'b0, -1, -1);   // memory cycle
        idle(2);
        chk("u0 Addr held after ignored frames", addr_o[0], 8'hA5);

        // SYNC_WAIT=3 target
        frame(1, 4'h0, 16'h0710, 8'h96, 1'b1, -1, -1);   // long-wait read
        frame(1, 4'h0, 16'h0720, 8'h77, 1'b1,  9, -1);   // aborted during SYNC wait
        idle(2);
        frame(1, 4'h2, 16'h07FF, 8'h81, 1'b1, -1, -1);   // write after abort
        idle(2);

        // Reset in the first RDAT clock, then a normal write
        frame(0, 4'h0, 16'h0733, 8'h4E, 1'b1, -1, 9);
        idle(2);
        frame(0, 4'h2, 16'h0711, 8'h3C, 1'b1, -1, -1);
        frame(0, 4'h0, 16'h0700, 8'hE1, 1'b1, -1, -1);
        idle(4);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL leftover events: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
